// File: rtl/cmd_reply_packer.sv
// Collects 16-bit reply words into a 256-entry buffer, then emits one fixed
// 256-word packet (header, timestamp, payload, zero pad) to the RX FIFO.
module cmd_reply_packer #(
  parameter logic [4:0] CHAN      = 5'h1F,
  parameter int         MAX_WORDS = 252
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [31:0] timestamp_clock,
  input  logic        rx_WR,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  input  logic        have_space,
  output logic        wrreq,
  output logic [15:0] wrdata,
  output logic        overflow
);

  localparam logic [8:0] MAXW    = 9'(MAX_WORDS);
  localparam logic [8:0] BODY_M1 = 9'd251;  // last body index: 256 words minus 4 header words

  typedef enum logic [2:0] {ACCUM, WAIT_SPACE, HDR0, HDR1, TS0, TS1, PAYLOAD, PAD} state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  rd_idx_q, rd_idx_d;
  logic [31:0] ts_q, ts_d;
  logic        wrreq_q, wrreq_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic        overflow_q, overflow_d;

  logic [15:0] mem [256];
  logic        accept;
  logic        mem_we;
  logic [31:0] header;

  assign header = {3'b000, 1'b1, 1'b1, 6'b0, CHAN, 7'b0, cnt_q[7:0], 1'b0};

  always_ff @(posedge txclk) begin
    if (mem_we) mem[cnt_q[7:0]] <= rx_databus;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    ts_d       = ts_q;
    wrreq_d    = 1'b0;
    wrdata_d   = 16'h0000;
    accept     = (state_q == ACCUM) && (cnt_q < MAXW);
    mem_we     = rx_WR && accept;
    overflow_d = overflow_q | (rx_WR & ~accept);

    case (state_q)
      ACCUM: begin
        if (mem_we) cnt_d = cnt_q + 9'd1;
        // Size threshold uses the pre-write count so the second word of a
        // pair started at MAX_WORDS-2 still lands before the flush.
        if ((cnt_q >= MAXW - 9'd1) || (rx_WR_done && cnt_d != 9'd0)) begin
          state_d = WAIT_SPACE;
          ts_d    = timestamp_clock;
        end
      end
      WAIT_SPACE: if (have_space) state_d = HDR0;
      HDR0: begin
        wrreq_d  = 1'b1;
        wrdata_d = header[15:0];
        state_d  = HDR1;
      end
      HDR1: begin
        wrreq_d  = 1'b1;
        wrdata_d = header[31:16];
        state_d  = TS0;
      end
      TS0: begin
        wrreq_d  = 1'b1;
        wrdata_d = ts_q[15:0];
        state_d  = TS1;
      end
      TS1: begin
        wrreq_d  = 1'b1;
        wrdata_d = ts_q[31:16];
        rd_idx_d = 9'd0;
        state_d  = PAYLOAD;
      end
      PAYLOAD: begin
        wrreq_d  = 1'b1;
        wrdata_d = mem[rd_idx_q[7:0]];
        rd_idx_d = rd_idx_q + 9'd1;
        if (rd_idx_q == cnt_q - 9'd1) begin
          if (rd_idx_q == BODY_M1) begin
            state_d  = ACCUM;
            cnt_d    = 9'd0;
            rd_idx_d = 9'd0;
          end else begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        wrreq_d  = 1'b1;
        rd_idx_d = rd_idx_q + 9'd1;
        if (rd_idx_q == BODY_M1) begin
          state_d  = ACCUM;
          cnt_d    = 9'd0;
          rd_idx_d = 9'd0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q    <= ACCUM;
      cnt_q      <= 9'd0;
      rd_idx_q   <= 9'd0;
      ts_q       <= 32'd0;
      wrreq_q    <= 1'b0;
      wrdata_q   <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      ts_q       <= ts_d;
      wrreq_q    <= wrreq_d;
      wrdata_q   <= wrdata_d;
      overflow_q <= overflow_d;
    end
  end

  assign rx_WR_enabled = (state_q == ACCUM) && (cnt_q <= MAXW - 9'd2);
  assign wrreq         = wrreq_q;
  assign wrdata        = wrdata_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_cmd_reply_packer.sv
// Directed bench for cmd_reply_packer: expected FIFO words are queued when a
// packet is set up and popped as the DUT writes them.
module tb_cmd_reply_packer;

  logic        txclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] timestamp_clock = 32'd0;
  logic        rx_WR = 1'b0;
  logic [15:0] rx_databus = 16'h0;
  logic        rx_WR_done = 1'b0;
  logic        rx_WR_enabled;
  logic        have_space = 1'b0;
  logic        wrreq;
  logic [15:0] wrdata;
  logic        overflow;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] q[$];
  logic [15:0] pay[256];
  logic [15:0] m_exp;
  int          wr_cycles = 0;
  int          seen = 0;
  int          run = 0;

  cmd_reply_packer #(.CHAN(5'h1F), .MAX_WORDS(252)) dut (
    .txclk(txclk), .reset(reset), .timestamp_clock(timestamp_clock),
    .rx_WR(rx_WR), .rx_databus(rx_databus), .rx_WR_done(rx_WR_done),
    .rx_WR_enabled(rx_WR_enabled), .have_space(have_space),
    .wrreq(wrreq), .wrdata(wrdata), .overflow(overflow)
  );

  always #5 txclk = ~txclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic wr(input logic [15:0] w);
    rx_WR      = 1'b1;
    rx_databus = w;
    tick();
    rx_WR      = 1'b0;
  endtask

  task automatic done_pulse();
    rx_WR_done = 1'b1;
    tick();
    rx_WR_done = 1'b0;
  endtask

  // Expected packet: header, timestamp, payload, zero pad to 256 words.
  task automatic push_pkt(input int n, input logic [31:0] ts);
    logic [31:0] h;
    h = 32'h1800_0000 | (32'h1F << 16) | 32'(n * 2);
    q.push_back(h[15:0]);
    q.push_back(h[31:16]);
    q.push_back(ts[15:0]);
    q.push_back(ts[31:16]);
    for (int i = 0; i < n; i++) q.push_back(pay[i]);
    for (int i = n; i < 252; i++) q.push_back(16'h0000);
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (q.size() == 0 && !wrreq && run == 0) ok = 1'b1;
    end
    if (!ok) chk({tag, "_drain_timeout"}, q.size(), 0);
  endtask

  always @(negedge txclk) begin
    if (reset) begin
      run = 0;
    end else if (wrreq) begin
      wr_cycles++;
      seen++;
      run++;
      if (q.size() > 0) begin
        m_exp = q.pop_front();
        chk("wrdata", {15'b0, 1'b1, wrdata}, {15'b0, 1'b1, m_exp});
      end else begin
        chk("wrreq_unexpected", {15'b0, 1'b1, wrdata}, 32'h0);
      end
    end else if (run != 0) begin
      chk("burst_len", run, 256);
      run = 0;
    end
  end

  initial begin
    int w0;
    // Reset state
    repeat (3) tick();
    chk("rst_wrreq", wrreq, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    chk("rst_enabled", rx_WR_enabled, 1);
    tick();
    chk("post_rst_enabled", rx_WR_enabled, 1);

    // Basic two-word packet
    have_space      = 1'b1;
    timestamp_clock = 32'h0000_1234;
    pay[0] = 16'h0102;
    pay[1] = 16'h0002;
    push_pkt(2, 32'h0000_1234);
    wr(16'h0102);
    wr(16'h0002);
    done_pulse();
    wait_drain("basic");

    // Full buffer: 126 back-to-back pairs, no done
    have_space      = 1'b0;
    timestamp_clock = 32'hCAFE_0001;
    for (int i = 0; i < 252; i++) pay[i] = 16'hA500 ^ 16'(i);
    for (int i = 0; i < 250; i++) wr(pay[i]);
    chk("full_en_at250", rx_WR_enabled, 1);
    wr(pay[250]);
    chk("full_en_at251", rx_WR_enabled, 0);
    wr(pay[251]);
    chk("full_en_at252", rx_WR_enabled, 0);
    w0 = wr_cycles;
    repeat (5) tick();
    chk("full_no_wr_while_no_space", wr_cycles - w0, 0);
    push_pkt(252, 32'hCAFE_0001);
    have_space = 1'b1;
    wait_drain("full");
    chk("full_overflow", overflow, 0);

    // Empty done pulses never flush
    w0 = wr_cycles;
    for (int i = 0; i < 100; i++) begin
      rx_WR_done = i[0];
      tick();
    end
    rx_WR_done = 1'b0;
    chk("empty_no_wrreq", wr_cycles - w0, 0);
    chk("empty_enabled", rx_WR_enabled, 1);

    // Flush stalled on have_space, extra word dropped
    have_space      = 1'b0;
    timestamp_clock = 32'hDEAD_BEEF;
    pay[0] = 16'h1111;
    pay[1] = 16'h2222;
    pay[2] = 16'h3333;
    wr(pay[0]);
    wr(pay[1]);
    wr(pay[2]);
    done_pulse();
    timestamp_clock = 32'h0;
    w0 = wr_cycles;
    for (int i = 0; i < 50; i++) begin
      rx_WR      = (i == 10);
      rx_databus = 16'hBAD0;
      tick();
    end
    rx_WR = 1'b0;
    chk("stall_no_wrreq", wr_cycles - w0, 0);
    chk("stall_overflow", overflow, 1);
    push_pkt(3, 32'hDEAD_BEEF);
    have_space = 1'b1;
    wait_drain("stall");
    chk("stall_overflow_sticky", overflow, 1);

    // Reset in the middle of the payload
    timestamp_clock = 32'h0000_0077;
    for (int i = 0; i < 20; i++) pay[i] = 16'h3000 + 16'(i);
    push_pkt(20, 32'h0000_0077);
    for (int i = 0; i < 20; i++) wr(pay[i]);
    done_pulse();
    w0 = seen;
    for (int i = 0; i < 500 && (seen - w0) < 14; i++) tick();
    chk("abort_reached_word10", seen - w0, 14);
    reset = 1'b1;
    q.delete();
    tick();
    chk("abort_wrreq", wrreq, 0);
    chk("abort_wrdata", wrdata, 0);
    chk("abort_overflow_cleared", overflow, 0);
    reset = 1'b0;
    chk("abort_enabled", rx_WR_enabled, 1);
    w0 = wr_cycles;
    repeat (3) tick();
    chk("abort_quiet", wr_cycles - w0, 0);
    timestamp_clock = 32'h00C0_FFEE;
    pay[0] = 16'hAAAA;
    pay[1] = 16'h5555;
    push_pkt(2, 32'h00C0_FFEE);
    wr(pay[0]);
    wr(pay[1]);
    done_pulse();
    wait_drain("after_abort");

    // Word and done in the same cycle
    timestamp_clock = 32'h1357_9BDF;
    for (int i = 0; i < 4; i++) pay[i] = 16'h0A01 + 16'(i);
    push_pkt(4, 32'h1357_9BDF);
    wr(pay[0]);
    wr(pay[1]);
    wr(pay[2]);
    rx_WR_done = 1'b1;
    wr(pay[3]);
    rx_WR_done = 1'b0;
    wait_drain("same_cycle");
    chk("same_cycle_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
